gen_break_mc: RTL and testbench
===============================

Name: gen_break_mc

Overview:
Multi-channel successor to the core break generator. Drives the single `break_encore` halt request to the encore core from three sources:
- a synchronised irq2,
- irq2_full,
- an MMIO stall arbitrated among NUM_CH independent MMIO sync channels.

Each channel is latched as pending, granted round-robin, and held in stall until that channel's synchronised turn2run returns. An optional watchdog aborts a stall that never resumes.

Parameters:
NUM_CH, 4, number of MMIO sync/resume channels (>=1)
SYNC_STAGES, 2, flop stages on irq2 and each turn2run bit (>=1)
TIMEOUT_W, 16, width of stall watchdog counter and limit

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
irq2  in  1  async-domain break request, synchronised internally
irq2_full  in  1  immediate break request, unregistered path
wenable  in  1  core write enable of current access
isMMIO  in  1  current access targets MMIO
sync_valid  in  NUM_CH  per-channel MMIO sync request, level or pulse
turn2run  in  NUM_CH  per-channel resume, async-domain
timeout_limit  in  TIMEOUT_W  stall watchdog limit; 0 disables
break_encore  out  1  halt request to core
irq_mmio  out  1  MMIO stall active (registered)
active_ch  out  max(1,$clog2(NUM_CH))  channel currently stalled/last granted
pending  out  NUM_CH  latched, not-yet-served requests
timeout_err  out  1  one-cycle pulse on watchdog abort
debug_state  out  3  current FSM state

Behaviour:
- Reset is clk, resetn synchronous active-low. All of the following clear to 0: state, irq_mmio, active_ch, pending, timeout_err, rr_ptr, stall counter, all sync flops.
- `break_encore` is combinational: `(irq2_s & ~(isMMIO & wenable)) | irq2_full | irq_mmio`. `irq2_s` is irq2 after SYNC_STAGES flops.
- `turn2run_s[i]` is turn2run[i] after SYNC_STAGES flops.
- Pending capture: every cycle, `pending <= (pending | sync_valid) & ~grant_mask`.
  - grant_mask is one-hot of the channel granted this cycle, else 0.
  - A request arriving in the grant cycle on the granted channel is consumed by that grant.
  - A request on another channel in that cycle stays pending.
- req = pending | sync_valid.
- FSM states (debug_state encoding):
  - INIT=0: irq_mmio<=0; next ARM.
  - ARM=1:
    - If req != 0, grant the first set bit searching from rr_ptr upward with wrap to 0.
    - On grant: active_ch<=g, rr_ptr<=(g+1) mod NUM_CH, irq_mmio<=1, counter<=0; next STALL.
    - Else hold.
  - STALL=2:
    - If turn2run_s[active_ch]: irq_mmio<=0, next INIT.
    - Else if the timeout feature is compiled in, timeout_limit!=0 and counter==timeout_limit-1: next ABORT.
    - Else counter<=counter+1, saturating at all-ones.
  - ABORT=3: irq_mmio<=0, timeout_err<=1 for exactly this one cycle; next INIT. active_ch retains the aborted channel.
  - Codes 4-7: unreachable; if entered, go to INIT with irq_mmio<=0.
- Latency:
  - sync_valid in ARM → irq_mmio high next cycle.
  - turn2run edge → irq_mmio low SYNC_STAGES+1 cycles later.
  - After stall release, minimum 2 cycles (INIT, ARM) before the next grant goes high.
- turn2run on non-active channels is ignored.
- turn2run_s[active_ch] and the timeout condition true in the same cycle: resume wins; no timeout_err.
- NUM_CH=1: active_ch is constant 0; rr_ptr is unused.
- Reset mid-stall: irq_mmio drops the cycle after resetn low is sampled; all pending requests are lost.

Optional Feature:
Macro `GEN_BREAK_TIMEOUT_EN`.
- Defined: stall counter and ABORT path exist as described.
- Undefined:
  - No counter logic.
  - STALL leaves only on turn2run_s[active_ch].
  - timeout_limit is ignored; timeout_err is tied 0.
  - ABORT is unreachable; code 3 maps to INIT like 4-7.

Test Plan:
1. Reset, irq2=1 held, isMMIO=0 → break_encore rises 2 cycles after irq2 (SYNC_STAGES=2). With isMMIO=1, wenable=1 → break_encore=0. irq2_full=1 → break_encore=1 same cycle.
2. ch1 sync_valid 1-cycle pulse in ARM → next cycle irq_mmio=1, active_ch=1, debug_state=2. Pulse turn2run[1] → irq_mmio=0 exactly 3 cycles later, debug_state=0.
3. sync_valid=4'b1011 in one cycle with rr_ptr=0 → grants in order ch0, ch1, ch3. pending reads 4'b1010 after the first grant, 4'b1000 after the second, 0 after the third.
4. During ch0 stall, pulse turn2run[2] and sync_valid[2] → stall holds, pending[2]=1. Release ch0 → ch2 granted 2 cycles after irq_mmio falls.
5. GEN_BREAK_TIMEOUT_EN defined, timeout_limit=5, no turn2run → state 2 for 5 cycles, then 3, timeout_err=1 for one cycle, then 0. timeout_limit=0 → stall indefinitely.
6. resetn low while debug_state=2 → irq_mmio=0, pending=0, debug_state=0 after the reset edge. turn2run_s and timeout coinciding → no timeout_err.

Source files
------------

// File: rtl/gen_break_mc_if.sv
// Signal bundle between the encore core/MMIO fabric and gen_break_mc.
// The master drives the requests, and the slave (the break generator) drives the halt/status outputs.
interface gen_break_mc_if #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned TIMEOUT_W = 16
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                 irq2;
    logic                 irq2_full;
    logic                 wenable;
    logic                 isMMIO;
    logic [NUM_CH-1:0]    sync_valid;
    logic [NUM_CH-1:0]    turn2run;
    logic [TIMEOUT_W-1:0] timeout_limit;
    logic                 break_encore;
    logic                 irq_mmio;
    logic [CH_W-1:0]      active_ch;
    logic [NUM_CH-1:0]    pending;
    logic                 timeout_err;
    logic [2:0]           debug_state;

    modport master (
        output irq2, irq2_full, wenable, isMMIO, sync_valid, turn2run, timeout_limit,
        input  break_encore, irq_mmio, active_ch, pending, timeout_err, debug_state
    );

    modport slave (
        input  irq2, irq2_full, wenable, isMMIO, sync_valid, turn2run, timeout_limit,
        output break_encore, irq_mmio, active_ch, pending, timeout_err, debug_state
    );
endinterface

// File: rtl/gen_break_mc.sv
// Multi-channel break generator: irq2, irq2_full and a round-robin MMIO stall drive break_encore.
// Optional stall watchdog is compiled in with GEN_BREAK_TIMEOUT_EN.
module gen_break_mc #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_W   = 16
) (
    input logic          clk,
    input logic          resetn,
    gen_break_mc_if.slave bus
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {
        StInit  = 3'd0,
        StArm   = 3'd1,
        StStall = 3'd2,
        StAbort = 3'd3
    } state_e;

    state_e            state_q;
    logic              irq_mmio_q;
    logic [CH_W-1:0]   active_ch_q;
    logic [CH_W-1:0]   rr_ptr_q;
    logic [NUM_CH-1:0] pending_q;

    logic [SYNC_STAGES-1:0] irq2_sync_q;
    logic [NUM_CH-1:0]      t2r_sync_q [SYNC_STAGES];
    logic                   irq2_s;
    logic [NUM_CH-1:0]      turn2run_s;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            irq2_sync_q <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) t2r_sync_q[i] <= '0;
        end else begin
            irq2_sync_q[0] <= bus.irq2;
            t2r_sync_q[0]  <= bus.turn2run;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                irq2_sync_q[i] <= irq2_sync_q[i-1];
                t2r_sync_q[i]  <= t2r_sync_q[i-1];
            end
        end
    end

    assign irq2_s     = irq2_sync_q[SYNC_STAGES-1];
    assign turn2run_s = t2r_sync_q[SYNC_STAGES-1];

    logic [NUM_CH-1:0] req;
    logic              grant_valid;
    logic [CH_W-1:0]   grant_idx;
    logic              grant_fire;
    logic [NUM_CH-1:0] grant_mask;
    logic [CH_W-1:0]   rr_next;

    assign req = pending_q | bus.sync_valid;

    // First requester at or above rr_ptr, wrapping to channel 0.
    always_comb begin
        int unsigned j;
        j           = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            j = k + 32'(rr_ptr_q);
            if (j >= NUM_CH) j = j - NUM_CH;
            if (!grant_valid && req[j]) begin
                grant_valid = 1'b1;
                grant_idx   = CH_W'(j);
            end
        end
    end

    assign grant_fire = (state_q == StArm) && grant_valid;
    assign grant_mask = grant_fire ? (NUM_CH'(1) << grant_idx) : '0;
    assign rr_next    = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;

`ifdef GEN_BREAK_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] cnt_q;
    logic                 timeout_err_q;
    logic                 timeout_hit;

    assign timeout_hit = (bus.timeout_limit != '0) && (cnt_q == bus.timeout_limit - 1'b1);
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= StInit;
            irq_mmio_q  <= 1'b0;
            active_ch_q <= '0;
            rr_ptr_q    <= '0;
            pending_q   <= '0;
`ifdef GEN_BREAK_TIMEOUT_EN
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            pending_q <= req & ~grant_mask;
`ifdef GEN_BREAK_TIMEOUT_EN
            timeout_err_q <= 1'b0;
`endif
            case (state_q)
                StInit: begin
                    irq_mmio_q <= 1'b0;
                    state_q    <= StArm;
                end
                StArm: begin
                    if (grant_valid) begin
                        active_ch_q <= grant_idx;
                        rr_ptr_q    <= rr_next;
                        irq_mmio_q  <= 1'b1;
                        state_q     <= StStall;
`ifdef GEN_BREAK_TIMEOUT_EN
                        cnt_q <= '0;
`endif
                    end
                end
                StStall: begin
                    // Resume takes priority over a coincident watchdog expiry.
                    if (turn2run_s[active_ch_q]) begin
                        irq_mmio_q <= 1'b0;
                        state_q    <= StInit;
`ifdef GEN_BREAK_TIMEOUT_EN
                    end else if (timeout_hit) begin
                        timeout_err_q <= 1'b1;
                        state_q       <= StAbort;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
`endif
                    end
                end
`ifdef GEN_BREAK_TIMEOUT_EN
                StAbort: begin
                    irq_mmio_q <= 1'b0;
                    state_q    <= StInit;
                end
`endif
                default: begin
                    irq_mmio_q <= 1'b0;
                    state_q    <= StInit;
                end
            endcase
        end
    end

    assign bus.break_encore = (irq2_s & ~(bus.isMMIO & bus.wenable)) | bus.irq2_full | irq_mmio_q;
    assign bus.irq_mmio     = irq_mmio_q;
    assign bus.active_ch    = active_ch_q;
    assign bus.pending      = pending_q;
    assign bus.debug_state  = state_q;
`ifdef GEN_BREAK_TIMEOUT_EN
    assign bus.timeout_err  = timeout_err_q;
`else
    assign bus.timeout_err  = 1'b0;
`endif
endmodule

// File: tb/tb_gen_break_mc.sv
// Self-checking bench for gen_break_mc: vector table for break_encore, directed stall sequences.
module tb_gen_break_mc;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    gen_break_mc_if #(.NUM_CH(4), .TIMEOUT_W(16)) bus ();

    gen_break_mc #(.NUM_CH(4), .SYNC_STAGES(2), .TIMEOUT_W(16)) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic irq2;
        logic irq2_full;
        logic is_mmio;
        logic wenable;
        logic exp_break;
    } be_vec_t;

    be_vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expects ARM; one cycle of sv then a grant of exp_ch leaving exp_pend behind.
    task automatic grant(input logic [3:0] sv, input int exp_ch, input logic [3:0] exp_pend);
        bus.sync_valid = sv;
        step(1);
        bus.sync_valid = '0;
        check("grant_irq_mmio", bus.irq_mmio, 1);
        check("grant_state", bus.debug_state, 2);
        check("grant_active_ch", bus.active_ch, exp_ch);
        check("grant_pending", bus.pending, exp_pend);
    endtask

    // One-cycle turn2run pulse; irq_mmio must fall exactly 3 cycles later, then ARM.
    task automatic release_ch(input int ch);
        bus.turn2run = 4'b0001 << ch;
        step(1);
        bus.turn2run = '0;
        step(1);
        check("release_hold", bus.irq_mmio, 1);
        step(1);
        check("release_irq_mmio", bus.irq_mmio, 0);
        check("release_state_init", bus.debug_state, 0);
        step(1);
        check("release_state_arm", bus.debug_state, 1);
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

        bus.irq2 = 0; bus.irq2_full = 0; bus.wenable = 0; bus.isMMIO = 0;
        bus.sync_valid = '0; bus.turn2run = '0; bus.timeout_limit = '0;

        // Reset state
        step(2);
        check("rst_irq_mmio", bus.irq_mmio, 0);
        check("rst_pending", bus.pending, 0);
        check("rst_state", bus.debug_state, 0);
        check("rst_active_ch", bus.active_ch, 0);
        check("rst_timeout_err", bus.timeout_err, 0);
        check("rst_break", bus.break_encore, 0);
        resetn = 1;
        step(1);
        check("post_rst_arm", bus.debug_state, 1);

        // irq2 synchroniser latency and masking
        bus.irq2 = 1;
        step(1);
        check("irq2_lat1", bus.break_encore, 0);
        step(1);
        check("irq2_lat2", bus.break_encore, 1);
        bus.isMMIO = 1; bus.wenable = 1;
        #1;
        check("irq2_masked", bus.break_encore, 0);
        bus.irq2_full = 1;
        #1;
        check("irq2_full_now", bus.break_encore, 1);

        for (int i = 0; i < 8; i++) begin
            bus.irq2 = vecs[i].irq2;
            bus.irq2_full = vecs[i].irq2_full;
            bus.isMMIO = vecs[i].is_mmio;
            bus.wenable = vecs[i].wenable;
            step(3);
            check($sformatf("vec%0d_break", i), bus.break_encore, vecs[i].exp_break);
        end
        bus.irq2 = 0; bus.irq2_full = 0; bus.isMMIO = 0; bus.wenable = 0;
        step(3);

        // Single channel stall/resume
        grant(4'b0010, 1, 4'b0000);
        release_ch(1);

        resetn = 0;
        step(1);
        resetn = 1;
        step(2);
        check("rerst_arm", bus.debug_state, 1);

        // Round robin from rr_ptr=0
        grant(4'b1011, 0, 4'b1010);
        release_ch(0);
        grant(4'b0000, 1, 4'b1000);
        release_ch(1);
        grant(4'b0000, 3, 4'b0000);
        release_ch(3);

        // Foreign turn2run ignored, new request kept pending
        grant(4'b0001, 0, 4'b0000);
        bus.turn2run = 4'b0100; bus.sync_valid = 4'b0100;
        step(1);
        bus.turn2run = '0; bus.sync_valid = '0;
        step(3);
        check("foreign_irq_mmio", bus.irq_mmio, 1);
        check("foreign_state", bus.debug_state, 2);
        check("foreign_active", bus.active_ch, 0);
        check("foreign_pending", bus.pending, 4'b0100);
        release_ch(0);
        grant(4'b0000, 2, 4'b0000);
        release_ch(2);

        // Watchdog limit 5
        bus.timeout_limit = 16'd5;
        grant(4'b0010, 1, 4'b0000);
        step(4);
        check("wd_still_stall", bus.debug_state, 2);
        check("wd_no_err_yet", bus.timeout_err, 0);
        step(1);
`ifdef GEN_BREAK_TIMEOUT_EN
        check("wd_abort_state", bus.debug_state, 3);
        check("wd_err_pulse", bus.timeout_err, 1);
        step(1);
        check("wd_init_state", bus.debug_state, 0);
        check("wd_err_clear", bus.timeout_err, 0);
        check("wd_irq_mmio", bus.irq_mmio, 0);
        check("wd_active_kept", bus.active_ch, 1);
        step(1);
        check("wd_arm", bus.debug_state, 1);
`else
        check("wd_ignored_state", bus.debug_state, 2);
        check("wd_ignored_err", bus.timeout_err, 0);
        release_ch(1);
`endif

        // Limit 0 never aborts
        bus.timeout_limit = '0;
        grant(4'b0010, 1, 4'b0000);
        step(20);
        check("wd0_state", bus.debug_state, 2);
        check("wd0_irq_mmio", bus.irq_mmio, 1);
        check("wd0_err", bus.timeout_err, 0);
        release_ch(1);

        // Resume coinciding with expiry: resume wins
        bus.timeout_limit = 16'd5;
        grant(4'b0100, 2, 4'b0000);
        step(2);
        bus.turn2run = 4'b0100;
        step(1);
        bus.turn2run = '0;
        step(2);
        check("tie_state", bus.debug_state, 0);
        check("tie_err", bus.timeout_err, 0);
        check("tie_irq_mmio", bus.irq_mmio, 0);
        step(1);
        check("tie_err_after", bus.timeout_err, 0);
        check("tie_arm", bus.debug_state, 1);

        // Reset mid-stall drops stall and pending
        bus.timeout_limit = '0;
        grant(4'b1001, 3, 4'b0001);
        resetn = 0;
        step(1);
        check("midrst_irq_mmio", bus.irq_mmio, 0);
        check("midrst_pending", bus.pending, 0);
        check("midrst_state", bus.debug_state, 0);
        check("midrst_active", bus.active_ch, 0);
        resetn = 1;
        step(2);
        check("midrst_arm", bus.debug_state, 1);
        check("midrst_pending_after", bus.pending, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
